// File: rtl/accum_bp_if.sv
// Control/data bundle for the accum_bp accumulator: stimulus inputs, registered results.
// master drives the operation inputs, slave is the accumulator itself.
interface accum_bp_if #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 16
);
    logic             EN;
    logic             LD;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] BP;
    logic             BPEN;
    logic             RESUME;
    logic [WIDTH-1:0] Q;
    logic             HIT;
    logic             HALTED;
    logic             OVF;
    logic [CNTW-1:0]  CNT;

    modport master (
        output EN, LD, D, A, BP, BPEN, RESUME,
        input  Q, HIT, HALTED, OVF, CNT
    );

    modport slave (
        input  EN, LD, D, A, BP, BPEN, RESUME,
        output Q, HIT, HALTED, OVF, CNT
    );
endinterface

// File: rtl/accum_bp.sv
// Parametrised wrap/saturate accumulator with sticky overflow, op counter and
// a breakpoint comparator that can freeze the datapath in a HALT state.
module accum_bp #(
    parameter int WIDTH         = 8,
    parameter int CNTW          = 16,
    parameter bit SAT           = 1'b0,
    parameter bit HALT_ON_MATCH = 1'b1
) (
    input  logic       CK,
    input  logic       CLR,
    accum_bp_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [CNTW-1:0]  CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    // Carry-out either wraps away or clamps the result to all-ones.
    function automatic logic [WIDTH-1:0] acc_result(input logic [WIDTH:0] sum);
        if (SAT && sum[WIDTH]) begin
            return ALL_ONES;
        end else begin
            return sum[WIDTH-1:0];
        end
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              hit_q, hit_d;
    logic              halted_q, halted_d;
    logic [WIDTH:0]    sum_s;
    logic [WIDTH-1:0]  acc_s;

    // Next-state and datapath update; the breakpoint compares the post-accumulate value.
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        hit_d   = 1'b0;
        sum_s   = {1'b0, q_q} + {1'b0, bus.A};
        acc_s   = acc_result(sum_s);

        case (state_q)
            ST_RUN: begin
                if (bus.LD) begin
                    q_d   = bus.D;
                    ovf_d = 1'b0;
                end else if (bus.EN) begin
                    q_d   = acc_s;
                    ovf_d = ovf_q | sum_s[WIDTH];
                    cnt_d = cnt_q + CNT_ONE;
                    if (bus.BPEN && (acc_s == bus.BP)) begin
                        hit_d = 1'b1;
                        if (HALT_ON_MATCH) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        hit_d = 1'b0;
                    end
                end else begin
                    q_d = q_q;
                end
            end
            ST_HALT: begin
                // Resume edge only leaves HALT; EN/LD on that same edge are dropped.
                if (bus.RESUME) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALT;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        halted_d = (state_d == ST_HALT);
    end

    // State and output registers, cleared immediately by CLR.
    always_ff @(posedge CK or posedge CLR) begin
        if (CLR) begin
            state_q  <= ST_RUN;
            q_q      <= {WIDTH{1'b0}};
            cnt_q    <= {CNTW{1'b0}};
            ovf_q    <= 1'b0;
            hit_q    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            hit_q    <= hit_d;
            halted_q <= halted_d;
        end
    end

    assign bus.Q      = q_q;
    assign bus.CNT    = cnt_q;
    assign bus.OVF    = ovf_q;
    assign bus.HIT    = hit_q;
    assign bus.HALTED = halted_q;

endmodule
